prog_loader: RTL

Streams node programs into the array of execution cores after reset and holds the cores in reset until every node has its program. Words arrive over a valid/ready stream as a per-node header followed by instruction words. The loader writes them into a flat program store and drives each core's `pLength` and `prog` inputs. It sits directly upstream of the cores: its outputs are the cores' program and length inputs and their reset.

---
 rtl/prog_loader.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// prog_loader: streams per-node programs (header + body words) into a flat
// program store and holds the execution cores in reset until every node is
// loaded.
//
// Optional feature macro: PROG_LOADER_CHECKSUM_EN
//   When defined, a running XOR of all header/body words is kept and one
//   extra checksum word must follow the last node (CHK state) before DONE.
//
// Ports:
//   clk       - clock, all state changes on rising edge
//   rst       - synchronous active-high reset
//   start     - one-cycle pulse, begins a (re)load from IDLE/DONE/ERR
//   in_data   - stream word (header: len in [4:0]; body: instruction)
//   in_valid  - in_data valid
//   in_ready  - loader accepts in_data this cycle
//   prog      - program store, node n slot s at [(n*SLOTS+s)*IW +: IW]
//   plen      - per-node program length, node n at [n*4 +: 4]
//   core_rst  - reset to all cores, high until load completes
//   done      - load completed successfully
//   err       - load aborted on malformed stream
module prog_loader #(
  parameter int unsigned NODES = 12,
  parameter int unsigned SLOTS = 15,
  parameter int unsigned IW    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [IW-1:0]               in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [NODES*SLOTS*IW-1:0]   prog,
  output logic [NODES*4-1:0]          plen,
  output logic                        core_rst,
  output logic                        done,
  output logic                        err
);

  localparam int unsigned NW = (NODES > 1) ? $clog2(NODES) : 1;
  localparam int unsigned LW = 4;
  localparam int unsigned PW = NODES * SLOTS * IW;

`ifdef PROG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_BODY, S_CHK, S_DONE, S_ERR} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_BODY, S_DONE, S_ERR} state_e;
`endif

  state_e          state_q, state_d;
  logic [NW-1:0]   node_q, node_d;
  logic [LW-1:0]   slot_q, slot_d;
  logic [LW-1:0]   len_q, len_d;
  logic [PW-1:0]   prog_q, prog_d;
  logic [NODES*LW-1:0] plen_q, plen_d;
  logic            core_rst_q, core_rst_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            in_ready_q, in_ready_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [IW-1:0]   xor_q, xor_d;
`endif

  logic            accept;
  logic            node_cmp;
  logic [4:0]      hdr_len;

  assign accept  = in_valid && in_ready_q;
  assign hdr_len = in_data[4:0];

  // Next-state, store-write and output decode
  always_comb begin
    state_d    = state_q;
    node_d     = node_q;
    slot_d     = slot_q;
    len_d      = len_q;
    prog_d     = prog_q;
    plen_d     = plen_q;
    core_rst_d = core_rst_q;
    done_d     = done_q;
    err_d      = err_q;
    node_cmp   = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    xor_d      = xor_q;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_HDR;
          node_d     = '0;
          slot_d     = '0;
          core_rst_d = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
          xor_d      = '0;
`endif
        end
      end
      S_HDR: begin
        if (accept) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          xor_d = xor_q ^ in_data;
`endif
          if (hdr_len > 5'(SLOTS)) begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            core_rst_d = 1'b1;
          end else begin
            // Reloading a node wipes stale words so unfilled slots read 0
            for (int unsigned s = 0; s < SLOTS; s++) begin
              prog_d[(32'(node_q) * SLOTS + s) * IW +: IW] = '0;
            end
            plen_d[32'(node_q) * LW +: LW] = hdr_len[3:0];
            len_d  = hdr_len[3:0];
            slot_d = '0;
            if (hdr_len == 5'd0) node_cmp = 1'b1;
            else                 state_d  = S_BODY;
          end
        end
      end
      S_BODY: begin
        if (accept) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          xor_d = xor_q ^ in_data;
`endif
          prog_d[(32'(node_q) * SLOTS + 32'(slot_q)) * IW +: IW] = in_data;
          slot_d = LW'(slot_q + LW'(1));
          if (LW'(slot_q + LW'(1)) == len_q) node_cmp = 1'b1;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          if (in_data == xor_q) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            core_rst_d = 1'b0;
          end else begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            core_rst_d = 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Node finished: advance to next header or wrap up the load
    if (node_cmp) begin
      if (node_q == NW'(NODES - 1)) begin
`ifdef PROG_LOADER_CHECKSUM_EN
        state_d    = S_CHK;
`else
        state_d    = S_DONE;
        done_d     = 1'b1;
        core_rst_d = 1'b0;
`endif
      end else begin
        node_d  = NW'(node_q + NW'(1));
        state_d = S_HDR;
      end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    in_ready_d = (state_d == S_HDR) || (state_d == S_BODY) || (state_d == S_CHK);
`else
    in_ready_d = (state_d == S_HDR) || (state_d == S_BODY);
`endif
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      node_q     <= '0;
      slot_q     <= '0;
      len_q      <= '0;
      prog_q     <= '0;
      plen_q     <= '0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      node_q     <= node_d;
      slot_q     <= slot_d;
      len_q      <= len_d;
      prog_q     <= prog_d;
      plen_q     <= plen_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
      in_ready_q <= in_ready_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
    end
  end

  assign in_ready = in_ready_q;
  assign prog     = prog_q;
  assign plen     = plen_q;
  assign core_rst = core_rst_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
